// File: rtl/song_sequencer.sv
// Note sequencer for the beep-song player: walks a note table in external synchronous ROM,
// times each note in beat units, inserts inter-note gaps and handles loop/one-shot/pause.
module song_sequencer #(
    parameter int BEAT_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 500_000,
    parameter int SONG_LEN   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        play,
    input  logic        pause,
    output logic [7:0]  rom_addr,
    input  logic [35:0] rom_data,
    output logic [31:0] cnt_max,
    output logic        tone_en,
    output logic [7:0]  note_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
    } state_t;

    localparam logic [7:0]  LAST_IDX  = 8'(SONG_LEN - 1);
    localparam logic [31:0] BEAT_LAST = 32'(BEAT_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

    state_t      state_reg, state_next;
    logic [7:0]  idx_reg, idx_next;
    logic [31:0] tick_reg, tick_next;
    logic [3:0]  beats_reg, beats_next;
    logic [31:0] gap_reg, gap_next;
    logic [31:0] cnt_max_reg, cnt_max_next;
    logic        tone_reg, tone_next;
    logic        do_advance, do_eos;

    logic [3:0]  dur;
    logic [31:0] pitch;
    assign dur   = rom_data[35:32];
    assign pitch = rom_data[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            idx_reg     <= 8'd0;
            tick_reg    <= 32'd0;
            beats_reg   <= 4'd0;
            gap_reg     <= 32'd0;
            cnt_max_reg <= 32'd0;
            tone_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            tick_reg    <= tick_next;
            beats_reg   <= beats_next;
            gap_reg     <= gap_next;
            cnt_max_reg <= cnt_max_next;
            tone_reg    <= tone_next;
        end
    end

    // Advance and end-of-song are resolved after the case so every path shares one rule.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        tick_next    = tick_reg;
        beats_next   = beats_reg;
        gap_next     = gap_reg;
        cnt_max_next = cnt_max_reg;
        tone_next    = tone_reg;
        do_advance   = 1'b0;
        do_eos       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                idx_next  = 8'd0;
                tone_next = 1'b0;
                if (play) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                if (dur == 4'd0) begin
                    if (idx_reg == 8'd0) begin
                        state_next = S_DONE;
                    end else begin
                        do_eos = 1'b1;
                    end
                end else begin
                    cnt_max_next = pitch;
                    beats_next   = dur;
                    tick_next    = 32'd0;
                    tone_next    = (pitch != 32'd0);
                    state_next   = S_PLAY;
                end
            end
            S_PLAY: begin
                if (pause) begin
                    tone_next = 1'b0;
                end else if (tick_reg == BEAT_LAST) begin
                    tick_next  = 32'd0;
                    beats_next = beats_reg - 4'd1;
                    if (beats_reg == 4'd1) begin
                        tone_next = 1'b0;
                        if (GAP_TICKS == 0) begin
                            do_advance = 1'b1;
                        end else begin
                            gap_next   = 32'd0;
                            state_next = S_GAP;
                        end
                    end else begin
                        tone_next = (cnt_max_reg != 32'd0);
                    end
                end else begin
                    tick_next = tick_reg + 32'd1;
                    tone_next = (cnt_max_reg != 32'd0);
                end
            end
            S_GAP: begin
                tone_next = 1'b0;
                if (!pause) begin
                    if (gap_reg == GAP_LAST) begin
                        do_advance = 1'b1;
                    end else begin
                        gap_next = gap_reg + 32'd1;
                    end
                end
            end
            S_DONE: begin
                tone_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (do_advance) begin
            if (idx_reg == LAST_IDX) begin
                do_eos = 1'b1;
            end else begin
                idx_next   = idx_reg + 8'd1;
                state_next = S_FETCH;
            end
        end

        // Mode is only looked at here, so mid-song toggles cannot restart or stop playback.
        if (do_eos) begin
            if (mode) begin
                idx_next   = 8'd0;
                state_next = S_FETCH;
            end else begin
                state_next = S_DONE;
            end
        end
    end

    always_comb begin
        busy = (state_reg != S_IDLE);
        done = (state_reg == S_DONE);
    end

    assign rom_addr = idx_reg;
    assign note_idx = idx_reg;
    assign cnt_max  = cnt_max_reg;
    assign tone_en  = tone_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small synchronous ROM model and per-cycle checks.
module tb_song_sequencer;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        play;
    logic        pause;
    logic [7:0]  rom_addr;
    logic [35:0] rom_data;
    logic [31:0] cnt_max;
    logic        tone_en;
    logic [7:0]  note_idx;
    logic        busy;
    logic        done;

    logic [35:0] rom_mem [0:3];
    int          checks;
    int          errors;
    int          cyc;
    logic        exp_tone;
    int          high_cnt;
    int          last_high;

    song_sequencer #(
        .BEAT_TICKS(4),
        .GAP_TICKS (2),
        .SONG_LEN  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .play    (play),
        .pause   (pause),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .cnt_max (cnt_max),
        .tone_en (tone_en),
        .note_idx(note_idx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rom_data <= rom_mem[rom_addr[1:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        rom_mem[0] = {4'd2, 32'd100};
        rom_mem[1] = {4'd1, 32'd0};
        rom_mem[2] = {4'd3, 32'd200};
        rom_mem[3] = {4'd1, 32'd50};
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_cnt_max"},  cnt_max,  0);
        chk({tag, "_tone_en"},  tone_en,  0);
        chk({tag, "_note_idx"}, note_idx, 0);
        chk({tag, "_busy"},     busy,     0);
        chk({tag, "_done"},     done,     0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b0;
        mode   = 1'b0;
        play   = 1'b0;
        pause  = 1'b0;
        load_table();

        // Reset values and idle behaviour
        #2;
        check_reset_values("por");
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc = c;
            chk("idle_busy", busy, 0);
            chk("idle_tone", tone_en, 0);
            step();
        end

        // One-shot with ignored play pulses and a mid-song mode toggle
        for (int c = 0; c < 48; c++) begin
            cyc  = c;
            play = (c == 0) || (c == 6) || (c == 25);
            mode = (c >= 8) && (c <= 30);
            exp_tone = (c >= 3 && c <= 10) || (c >= 23 && c <= 34) || (c >= 39 && c <= 42);
            chk("oneshot_tone", tone_en, exp_tone);
            if (c >= 3 && c <= 10)  chk("oneshot_cnt0", cnt_max, 100);
            if (c >= 15 && c <= 18) chk("oneshot_rest_cnt", cnt_max, 0);
            if (c >= 23 && c <= 34) chk("oneshot_cnt2", cnt_max, 200);
            if (c >= 39 && c <= 42) chk("oneshot_cnt3", cnt_max, 50);
            if (c == 1)  chk("oneshot_addr0", rom_addr, 0);
            if (c == 13) chk("oneshot_addr1", rom_addr, 1);
            if (c == 21) chk("oneshot_addr2", rom_addr, 2);
            if (c == 37) chk("oneshot_addr3", rom_addr, 3);
            if (c == 30) chk("oneshot_note_idx", note_idx, 2);
            chk("oneshot_done", done, (c == 45));
            chk("oneshot_busy", busy, (c >= 1 && c <= 45));
            step();
        end
        play = 1'b0;
        mode = 1'b0;

        // Loop: mode set mid-song, sampled at end-of-song; then reset mid-PLAY
        for (int c = 0; c <= 50; c++) begin
            cyc  = c;
            play = (c == 0);
            mode = (c >= 20);
            exp_tone = (c >= 3 && c <= 10) || (c >= 23 && c <= 34) ||
                       (c >= 39 && c <= 42) || (c >= 47 && c <= 50);
            chk("loop_tone", tone_en, exp_tone);
            chk("loop_done", done, 0);
            chk("loop_busy", busy, (c >= 1));
            if (c == 45) chk("loop_addr_wrap", rom_addr, 0);
            if (c == 48) chk("loop_cnt0", cnt_max, 100);
            if (c < 50) step();
        end
        play = 1'b0;
        rst  = 1'b0;
        #1;
        check_reset_values("async_rst");
        #1;
        rst  = 1'b1;
        mode = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            cyc = c;
            chk("post_rst_busy", busy, 0);
            chk("post_rst_tone", tone_en, 0);
        end

        // End marker at entry 1, one-shot
        load_table();
        rom_mem[1] = 36'd0;
        mode = 1'b0;
        for (int c = 0; c < 18; c++) begin
            cyc  = c;
            play = (c == 0);
            chk("eom1_tone", tone_en, (c >= 3 && c <= 10));
            chk("eom1_done", done, (c == 15));
            chk("eom1_busy", busy, (c >= 1 && c <= 15));
            step();
        end

        // End marker at entry 0 with loop mode: must not loop
        rom_mem[0] = 36'd0;
        mode = 1'b1;
        for (int c = 0; c < 11; c++) begin
            cyc  = c;
            play = (c == 0);
            chk("eom0_tone", tone_en, 0);
            chk("eom0_done", done, (c == 3));
            chk("eom0_busy", busy, (c >= 1 && c <= 3));
            step();
        end
        play = 1'b0;
        mode = 1'b0;

        // Pause for 5 cycles in the middle of note 0
        load_table();
        high_cnt  = 0;
        last_high = -1;
        for (int c = 0; c < 20; c++) begin
            cyc   = c;
            play  = (c == 0);
            pause = (c >= 5) && (c <= 9);
            exp_tone = (c >= 3 && c <= 5) || (c >= 11 && c <= 15);
            chk("pause_tone", tone_en, exp_tone);
            if (c == 8) chk("pause_cnt_hold", cnt_max, 100);
            if (tone_en === 1'b1) begin
                high_cnt++;
                last_high = c;
            end
            step();
        end
        pause = 1'b0;
        play  = 1'b0;
        chk("pause_high_total", high_cnt, 8);
        chk("pause_last_high", last_high, 15);

        rst = 1'b0;
        #1;
        check_reset_values("final_rst");
        rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
